// File: rtl/pipe_trace_tracker.sv
// Shadow pipeline that tracks PC/instr/decode fields per stage
// and emits a one-cycle retire record. Optional: PIPE_TRACE_SEQ_EN
module pipe_trace_tracker #(
    parameter int DEPTH     = 4,
    parameter int PC_W      = 32,
    parameter int INSTR_W   = 32,
    parameter int REG_IDX_W = 5,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_valid,
    input  logic [PC_W-1:0]      fetch_pc,
    input  logic [INSTR_W-1:0]   fetch_instr,
    input  logic [REG_IDX_W-1:0] dec_rs,
    input  logic [REG_IDX_W-1:0] dec_rt,
    input  logic [REG_IDX_W-1:0] dec_rd,
    input  logic [2:0]           dec_type,
    input  logic [DEPTH-2:0]     stall,
    input  logic [DEPTH-1:0]     flush,
`ifdef PIPE_TRACE_SEQ_EN
    output logic [7:0]           retire_seq,
    output logic                 seq_err,
`endif
    output logic                 retire_valid,
    output logic [PC_W-1:0]      retire_pc,
    output logic [INSTR_W-1:0]   retire_instr,
    output logic [REG_IDX_W-1:0] retire_rs,
    output logic [REG_IDX_W-1:0] retire_rt,
    output logic [REG_IDX_W-1:0] retire_rd,
    output logic [2:0]           retire_type,
    output logic [CNT_W-1:0]     retire_count,
    output logic [3:0]           occupancy
);

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [INSTR_W-1:0]   instr;
        logic [REG_IDX_W-1:0] rs;
        logic [REG_IDX_W-1:0] rt;
        logic [REG_IDX_W-1:0] rd;
        logic [2:0]           ty;
`ifdef PIPE_TRACE_SEQ_EN
        logic [7:0]           seq;
`endif
    } ent_t;

    ent_t             ent_q [DEPTH];
    ent_t             ent_d [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [DEPTH-1:0] hold;
    logic [3:0]       occ_d;

`ifdef PIPE_TRACE_SEQ_EN
    logic [7:0] seq_cnt;
    logic [7:0] last_seq;
    logic       have_last;
    logic [7:0] seq_diff;
`endif

    // Hold propagates backwards from any stalled stage
    always_comb begin
        logic acc;
        acc = 1'b0;
        hold = '0;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            acc = acc | stall[k];
            hold[k] = acc;
        end
    end

    // Next-state of every stage: hold, shift, bubble, then flush
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k];
        end
        vld_d = vld_q;
        if (!hold[0]) begin
            vld_d[0] = fetch_valid;
            ent_d[0].pc = fetch_pc;
            ent_d[0].instr = fetch_instr;
`ifdef PIPE_TRACE_SEQ_EN
            ent_d[0].seq = seq_cnt;
`endif
        end
        for (int k = 1; k < DEPTH; k++) begin
            if (!hold[k]) begin
                if (hold[k-1]) begin
                    vld_d[k] = 1'b0;
                end else begin
                    vld_d[k] = vld_q[k-1] & ~flush[k-1];
                    ent_d[k] = ent_q[k-1];
                    if (k == 1) begin
                        ent_d[k].rs = dec_rs;
                        ent_d[k].rt = dec_rt;
                        ent_d[k].rd = dec_rd;
                        ent_d[k].ty = dec_type;
                    end
                end
            end
        end
        for (int k = 0; k < DEPTH; k++) begin
            if (flush[k]) begin
                vld_d[k] = 1'b0;
            end
        end
        occ_d = 4'd0;
        for (int k = 0; k < DEPTH; k++) begin
            occ_d = occ_d + {3'b000, vld_d[k]};
        end
    end

    // Stage registers, occupancy and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            vld_q        <= '0;
            occupancy    <= 4'd0;
            retire_count <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= ent_d[k];
            end
            vld_q        <= vld_d;
            occupancy    <= occ_d;
            retire_count <= retire_count + CNT_W'(vld_q[DEPTH-1]);
        end
    end

    assign retire_valid = vld_q[DEPTH-1];
    assign retire_pc    = ent_q[DEPTH-1].pc;
    assign retire_instr = ent_q[DEPTH-1].instr;
    assign retire_rs    = ent_q[DEPTH-1].rs;
    assign retire_rt    = ent_q[DEPTH-1].rt;
    assign retire_rd    = ent_q[DEPTH-1].rd;
    assign retire_type  = ent_q[DEPTH-1].ty;

`ifdef PIPE_TRACE_SEQ_EN
    assign retire_seq = ent_q[DEPTH-1].seq;
    assign seq_diff   = ent_q[DEPTH-1].seq - last_seq;

    // Tag allocation and sticky ordering check at retire
    always_ff @(posedge clk) begin
        if (reset) begin
            seq_cnt   <= 8'd0;
            last_seq  <= 8'd0;
            have_last <= 1'b0;
            seq_err   <= 1'b0;
        end else begin
            if (fetch_valid && !hold[0]) begin
                seq_cnt <= seq_cnt + 8'd1;
            end
            if (vld_q[DEPTH-1]) begin
                if (have_last && (seq_diff == 8'd0 || seq_diff[7])) begin
                    seq_err <= 1'b1;
                end
                last_seq  <= ent_q[DEPTH-1].seq;
                have_last <= 1'b1;
            end
        end
    end
`endif

endmodule
